// File: rtl/adder_accumulator_if.sv
// Operand/result handshake bundle for adder_accumulator.
// master drives operands and result-ready; slave is the accumulator.
interface adder_accumulator_if #(parameter int CNT_W = 8);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [24:0]      in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [24:0]      out_data;
  logic                    out_ovf;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_count
  );
endinterface

// File: rtl/adder_accumulator.sv
// Frame accumulator over a 25-bit hybrid carry-select adder; one result per in_last frame.
// Define ADDER_ACC_SATURATE_EN to clamp the running sum on signed overflow instead of wrapping.

module csa_blk #(parameter int W = 5) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W-1:0] s0, s1;
  logic         c0, c1;
  assign {c0, s0} = {1'b0, a} + {1'b0, b};
  assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
  assign s    = cin ? s1 : s0;
  assign cout = cin ? c1 : c0;
endmodule

module hcsa25 (
  input  logic [24:0] a,
  input  logic [24:0] b,
  output logic [24:0] s,
  output logic        ovf
);
  localparam int BW = 5;
  localparam int NB = 5;
  logic [NB:0] c;
  assign c[0] = 1'b0;

  // Lowest block has a known carry-in, so it is a plain ripple add.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    if (g == 0) begin : g_rip
      assign {c[1], s[BW-1:0]} = {1'b0, a[BW-1:0]} + {1'b0, b[BW-1:0]};
    end else begin : g_sel
      csa_blk #(.W(BW)) u_blk (
        .a(a[g*BW +: BW]), .b(b[g*BW +: BW]), .cin(c[g]),
        .s(s[g*BW +: BW]), .cout(c[g+1])
      );
    end
  end

  // Carry into the MSB is a^b^s there; signed overflow is its mismatch with carry-out.
  assign ovf = c[NB] ^ a[24] ^ b[24] ^ s[24];
endmodule

module adder_accumulator #(parameter int CNT_W = 8) (
  input  logic                 clk,
  input  logic                 rst,
  adder_accumulator_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state;
  logic signed [24:0] acc, opa, sum, nxt_acc, o_data;
  logic               ovf, add_ovf, nxt_ovf, o_ovf, o_vld, rdy_q, fire;
  logic [CNT_W-1:0]   cnt, nxt_cnt, o_cnt;

  // First operand of a frame adds to zero so no state from the prior frame leaks in.
  assign opa = (state == IDLE) ? '0 : acc;

  hcsa25 u_add (.a(opa), .b(bus.in_data), .s(sum), .ovf(add_ovf));

  always_comb begin
    nxt_acc = sum;
`ifdef ADDER_ACC_SATURATE_EN
    if (add_ovf) nxt_acc = opa[24] ? 25'sh1000000 : 25'sh0FFFFFF;
`endif
  end

  assign nxt_cnt = (state == IDLE) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
  assign nxt_ovf = (state != IDLE) && (ovf || add_ovf);

  assign bus.in_ready  = rdy_q & ~rst;
  assign fire          = bus.in_valid & bus.in_ready;
  assign bus.out_valid = o_vld;
  assign bus.out_data  = o_data;
  assign bus.out_ovf   = o_ovf;
  assign bus.out_count = o_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
      rdy_q  <= 1'b1;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_ovf  <= 1'b0;
      o_cnt  <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: if (fire) begin
          acc <= nxt_acc;
          cnt <= nxt_cnt;
          ovf <= nxt_ovf;
          if (bus.in_last) begin
            state  <= HOLD;
            rdy_q  <= 1'b0;
            o_vld  <= 1'b1;
            o_data <= nxt_acc;
            o_ovf  <= nxt_ovf;
            o_cnt  <= nxt_cnt;
          end else begin
            state <= ACCUM;
          end
        end
        HOLD: if (bus.out_ready) begin
          state <= IDLE;
          rdy_q <= 1'b1;
          o_vld <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 Parameter: CNT_W, default 8, width of the operand counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand valid.
REQ-005 Port: in_ready  output  1  operand accepted when in_valid and in_ready are both 1.
REQ-006 Port: in_data  input  25  signed two's-complement operand.
REQ-007 Port: in_last  input  1  marks the final operand of a frame.
REQ-008 Port: out_valid  output  1  frame result valid.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: out_data  output  25  signed frame sum.
REQ-011 Port: out_ovf  output  1  sticky: at least one signed overflow occurred in the frame.
REQ-012 Port: out_count  output  CNT_W  number of operands accepted in the frame, saturating at 2^CNT_W-1.

Function
REQ-013 The block SHALL instantiate the team's 25-bit hybrid carry-select adder, with A = running accumulator and B = in_data, and SHALL use its sum and overflow outputs for every accumulation step.
REQ-014 FSM states: IDLE, ACCUM, HOLD.
REQ-015 IDLE: in_ready=1, out_valid=0; an accepted operand loads acc = 0 + in_data (through the adder), count=1, ovf=0; next state is HOLD if in_last=1, else ACCUM.
REQ-016 ACCUM: in_ready=1; an accepted operand updates acc from the adder result, increments count (saturating) and ORs the adder's overflow into ovf; next state is HOLD if in_last=1, else remains ACCUM. A cycle with no accepted operand leaves all state unchanged.
REQ-017 HOLD: in_ready=0, out_valid=1; out_data, out_ovf and out_count are held stable until out_ready=1, at which point the next state is IDLE.
REQ-018 Latency: out_valid rises on the cycle after the in_last operand is accepted. A frame of N operands therefore takes N+1 cycles to produce its result when in_valid is continuous.
REQ-019 out_data, out_ovf and out_count SHALL be driven directly from registers and SHALL be undefined-free (holding their last values) outside HOLD.
REQ-020 A single-operand frame (in_last=1 on the first operand) SHALL return out_data = in_data, out_ovf = 0, out_count = 1.
REQ-021 Operands are not accepted in HOLD; the throughput penalty is one bubble per frame, and there is no accept-and-release in the same cycle.

Reset
REQ-022 rst=1 at a clock edge SHALL force state=IDLE, acc=0, ovf=0, count=0, out_valid=0. It takes priority over every handshake, including a mid-frame reset in ACCUM and a result pending in HOLD, which is discarded.
REQ-023 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst is deasserted.

Configuration
REQ-024 Macro ADDER_ACC_SATURATE_EN controls saturation.
  - Defined: on an adder overflow, acc is clamped to +16777215 (0x0FFFFFF) when both inputs are non-negative, or to -16777216 (0x1000000) when both are negative. Later operands accumulate from the clamped value.
  - Undefined: acc takes the wrapped adder sum.
  - out_ovf behaves identically in both builds.

Verification
REQ-025 Operands 5, -3, 10 (last) with out_ready=1 -> out_data=12, out_ovf=0, out_count=3; out_valid is high for exactly one cycle, on the 4th cycle after the first accept.
REQ-026 Operands 0x0FFFFFF, 1 (last) -> out_ovf=1, out_count=2; out_data=0x0FFFFFF with the macro defined, 0x1000000 without it.
REQ-027 Operands -16777216, -1, 5 (last), macro defined -> out_data=-16777211, out_ovf=1.
REQ-028 Single operand -7 with in_last=1, out_ready held 0 for 3 cycles -> out_valid stays 1 and out_data stays -7 while in_ready=0, then the block returns to IDLE one cycle after out_ready=1.
REQ-029 Operands 4, 4, then rst pulsed for one cycle, then operand 9 (last) -> out_data=9, out_count=1, out_ovf=0.
REQ-030 With CNT_W=2, a frame of 5 operands of value 1 -> out_count=3 and out_data=5.
